// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator operand-entry path.
//   - key codes delivered by the keypad scanner
//   - op_t: 2-bit arithmetic operation selector
//   - entry_state_t: operand-entry controller states
//   - default operand digit count and width
package calc_pkg;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_WIDTH  = 14;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_OP_WAIT  = 3'd1,
    ST_ENTER_B  = 3'd2,
    ST_REQ      = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_RESULT   = 3'd5
  } entry_state_t;

endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: brings the scanner's asynchronous key-down level into the
// clk domain and turns each press into a single-cycle event.
//   clk, rst  : clock, asynchronous active-high reset
//   place     : key code from the scanner
//   pressed   : debounced key-down level (asynchronous)
//   key_evt   : one-cycle pulse on each rising edge of the synced level
//   key_code  : place, captured on the same edge that raises key_evt
module key_sync_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] place,
  input  logic       pressed,
  output logic       key_evt,
  output logic [3:0] key_code
);

  logic sync1;
  logic sync2;
  logic sync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      key_evt   <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      sync1     <= pressed;
      sync2     <= sync1;
      sync_prev <= sync2;
      key_evt   <= sync2 & ~sync_prev;
      // place is stable for as long as the key is held, so sampling it
      // alongside the edge gives the code of the key being pressed.
      key_code  <= place;
    end
  end

endmodule

// File: rtl/key_entry.sv
// key_entry: calculator operand-entry controller.
//   clk, rst          : clock, asynchronous active-high reset
//   place, pressed    : key code and key-down level from the scanner
//   op_a, op_b        : operands presented to the arithmetic unit
//   op_code           : operation (0 add, 1 sub, 2 mul, 3 div)
//   req_valid/ready   : request handshake to the arithmetic unit
//   res_value/valid   : result and its one-cycle strobe
//   disp_value        : value shown on the display
//   disp_digits       : digits entered in the current operand
//   busy              : request outstanding or result pending
//
// state       | meaning
// ENTER_A     | building first operand
// OP_WAIT     | operator chosen, waiting for first digit of B
// ENTER_B     | building second operand
// REQ         | request held until the arithmetic unit accepts it
// WAIT_RES    | waiting for the result strobe
// RESULT      | showing result; it becomes A if an operator follows
module key_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       place,
  input  logic             pressed,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       op_code,
  output logic             req_valid,
  input  logic             req_ready,
  input  logic [WIDTH-1:0] res_value,
  input  logic             res_valid,
  output logic [WIDTH-1:0] disp_value,
  output logic [2:0]       disp_digits,
  output logic             busy
);

  entry_state_t     state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       cnt;
  op_t              op;

  logic             key_evt;
  logic [3:0]       key_code;

  key_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .place    (place),
    .pressed  (pressed),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  logic             is_digit;
  logic             is_op;
  logic             fresh;
  logic [WIDTH-1:0] acc_cur;
  logic [WIDTH-1:0] acc_next;
  logic [2:0]       cnt_base;
  logic [2:0]       cnt_next;
  logic             digit_ok;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);

  // A digit arriving in OP_WAIT or RESULT starts a new operand, so the
  // shared x10+d datapath is fed zero and a zero count in those states.
  assign fresh    = (state == ST_OP_WAIT) || (state == ST_RESULT);
  assign acc_cur  = fresh ? '0 : ((state == ST_ENTER_B) ? b : a);
  assign cnt_base = fresh ? 3'd0 : cnt;
  assign acc_next = (acc_cur << 3) + (acc_cur << 1) + {{(WIDTH-4){1'b0}}, key_code};
  // Leading zeros are not counted: the count only moves once the value is nonzero.
  assign cnt_next = (acc_next != '0) ? cnt_base + 3'd1 : cnt_base;
  assign digit_ok = (cnt_base < 3'(DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ENTER_A;
      a         <= '0;
      b         <= '0;
      cnt       <= 3'd0;
      op        <= OP_ADD;
      req_valid <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_valid && req_ready) begin
            req_valid <= 1'b0;
            state     <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          // Clear takes priority: the pending result is abandoned.
          if (key_evt && key_code == KEY_CLR) begin
            a     <= '0;
            b     <= '0;
            cnt   <= 3'd0;
            op    <= OP_ADD;
            state <= ST_ENTER_A;
          end else if (res_valid) begin
            a     <= res_value;
            b     <= '0;
            cnt   <= 3'd0;
            state <= ST_RESULT;
          end
        end
        default: begin
          if (key_evt) begin
            if (key_code == KEY_CLR) begin
              a     <= '0;
              b     <= '0;
              cnt   <= 3'd0;
              op    <= OP_ADD;
              state <= ST_ENTER_A;
            end else if (is_digit) begin
              if (digit_ok) begin
                if (state == ST_ENTER_B || state == ST_OP_WAIT) begin
                  b <= acc_next;
                end else begin
                  a <= acc_next;
                end
                cnt <= cnt_next;
                if (state == ST_OP_WAIT) begin
                  state <= ST_ENTER_B;
                end else if (state == ST_RESULT) begin
                  state <= ST_ENTER_A;
                end
              end
            end else if (is_op) begin
              if (state != ST_ENTER_B) begin
                op    <= op_t'(2'(key_code - KEY_ADD));
                state <= ST_OP_WAIT;
              end
            end else if (key_code == KEY_EQ) begin
              if (state == ST_ENTER_B) begin
                req_valid <= 1'b1;
                state     <= ST_REQ;
              end
            end
          end
        end
      endcase
    end
  end

  assign op_a        = a;
  assign op_b        = b;
  assign op_code     = op;
  assign disp_digits = cnt;
  assign busy        = (state == ST_REQ) || (state == ST_WAIT_RES);
  assign disp_value  = (state == ST_ENTER_B || state == ST_REQ || state == ST_WAIT_RES) ? b : a;

endmodule

// File: tb/tb_key_entry.sv
module tb_key_entry;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       place = 4'd0;
  logic             pressed = 1'b0;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_code;
  logic             req_valid;
  logic             req_ready = 1'b0;
  logic [WIDTH-1:0] res_value = '0;
  logic             res_valid = 1'b0;
  logic [WIDTH-1:0] disp_value;
  logic [2:0]       disp_digits;
  logic             busy;

  key_entry #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .place       (place),
    .pressed     (pressed),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_code     (op_code),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .res_value   (res_value),
    .res_valid   (res_valid),
    .disp_value  (disp_value),
    .disp_digits (disp_digits),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes of the calculator as seen from the keypad.
  localparam int M_A = 0, M_OPW = 1, M_B = 2, M_REQ = 3, M_WAIT = 4, M_RES = 5;
  int m_mode, m_a, m_b, m_cnt, m_op, m_rv;
  int h1, h2, h3;          // pressed as seen at the last three edges
  int pend_evt, pend_code; // key event that becomes visible on the next edge

  task automatic model_clear();
    m_a = 0; m_b = 0; m_cnt = 0; m_op = 0; m_mode = M_A;
  endtask

  task automatic model_reset();
    model_clear();
    m_rv = 0; h1 = 0; h2 = 0; h3 = 0; pend_evt = 0; pend_code = 0;
  endtask

  task automatic model_key(input int k);
    if (k == 14) model_clear();
    else if (k <= 9) begin
      if (m_mode == M_A && m_cnt < DIGITS) begin
        m_a = m_a * 10 + k;
        if (m_a != 0) m_cnt++;
      end else if (m_mode == M_B && m_cnt < DIGITS) begin
        m_b = m_b * 10 + k;
        if (m_b != 0) m_cnt++;
      end else if (m_mode == M_OPW) begin
        m_b = k; m_cnt = (k != 0) ? 1 : 0; m_mode = M_B;
      end else if (m_mode == M_RES) begin
        m_a = k; m_cnt = (k != 0) ? 1 : 0; m_mode = M_A;
      end
    end else if (k <= 13) begin
      if (m_mode != M_B) begin m_op = k - 10; m_mode = M_OPW; end
    end else if (m_mode == M_B) begin
      m_mode = M_REQ; m_rv = 1;
    end
  endtask

  task automatic model_edge(input int s_pressed, input int s_place, input int s_ready,
                            input int s_rv, input int s_rval);
    int evt;
    if (m_mode == M_REQ) begin
      if (m_rv == 1 && s_ready == 1) begin m_rv = 0; m_mode = M_WAIT; end
    end else if (m_mode == M_WAIT) begin
      if (pend_evt == 1 && pend_code == 14) model_clear();
      else if (s_rv == 1) begin
        m_a = s_rval % (1 << WIDTH); m_b = 0; m_cnt = 0; m_mode = M_RES;
      end
    end else if (pend_evt == 1) begin
      model_key(pend_code);
    end
    // A press registers once the level has been high for two edges after being low.
    evt = (h2 == 1 && h3 == 0) ? 1 : 0;
    h3 = h2; h2 = h1; h1 = s_pressed;
    pend_evt = evt; pend_code = s_place;
  endtask

  function automatic int model_disp();
    if (m_mode == M_A || m_mode == M_OPW || m_mode == M_RES) return m_a;
    return m_b;
  endfunction

  initial begin
    int sp, spl, sr, srv, srval;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        sp = int'(pressed); spl = int'(place); sr = int'(req_ready);
        srv = int'(res_valid); srval = int'(res_value);
        #1;
        model_edge(sp, spl, sr, srv, srval);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("op_a", int'(op_a), m_a);
        chk("op_b", int'(op_b), m_b);
        chk("op_code", int'(op_code), m_op);
        chk("req_valid", int'(req_valid), m_rv);
        chk("disp_value", int'(disp_value), model_disp());
        chk("disp_digits", int'(disp_digits), m_cnt);
        chk("busy", int'(busy), (m_mode == M_REQ || m_mode == M_WAIT) ? 1 : 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (req_valid) rv_cycles++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic press(input int k, input int hold = 5);
    @(negedge clk);
    place = 4'(k);
    pressed = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic give_result(input int v);
    @(negedge clk);
    res_value = WIDTH'(v);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset disp_value", int'(disp_value), 0);
    chk("reset req_valid", int'(req_valid), 0);
    chk("reset busy", int'(busy), 0);

    // digit entry and the digit limit
    press(1); press(2); press(3);
    chk("123 value", int'(disp_value), 123);
    chk("123 digits", int'(disp_digits), 3);
    press(4); press(5);
    chk("limit value", int'(disp_value), 1234);
    chk("limit digits", int'(disp_digits), 4);
    press(14);

    // leading zeros
    press(0); press(0); press(7);
    chk("007 value", int'(disp_value), 7);
    chk("007 digits", int'(disp_digits), 1);
    press(14);

    // 12 + 30 with ready tied high
    req_ready = 1'b1;
    press(1); press(2); press(10); press(3); press(0);
    rv_cycles = 0;
    press(15);
    chk("add req_valid cycles", rv_cycles, 1);
    chk("add op_a", int'(op_a), 12);
    chk("add op_b", int'(op_b), 30);
    chk("add op_code", int'(op_code), 0);
    chk("add busy", int'(busy), 1);
    give_result(42);
    chk("add result", int'(disp_value), 42);
    chk("add result busy", int'(busy), 0);

    // chain from result, ready held low, clear during REQ ignored
    req_ready = 1'b0;
    press(11); press(2);
    rv_cycles = 0;
    press(15);
    press(14);
    chk("req held req_valid", int'(req_valid), 1);
    chk("req held cycles>5", (rv_cycles > 5) ? 1 : 0, 1);
    chk("req held op_a", int'(op_a), 42);
    chk("req held op_b", int'(op_b), 2);
    chk("req held op_code", int'(op_code), 1);
    @(negedge clk); req_ready = 1'b1;
    @(negedge clk); req_ready = 1'b0;
    chk("handshake req_valid", int'(req_valid), 0);
    chk("handshake busy", int'(busy), 1);
    give_result(40);
    chk("sub result", int'(disp_value), 40);
    press(6);
    chk("digit after result", int'(disp_value), 6);
    chk("digit after result digits", int'(disp_digits), 1);
    press(14);

    // clear in WAIT_RES abandons the result
    req_ready = 1'b1;
    press(5); press(12); press(3); press(15);
    chk("mul waiting busy", int'(busy), 1);
    press(14);
    give_result(99);
    chk("abandon disp", int'(disp_value), 0);
    chk("abandon busy", int'(busy), 0);
    chk("abandon op_a", int'(op_a), 0);

    // long hold gives one event
    press(7, 1000);
    chk("hold value", int'(disp_value), 7);
    chk("hold digits", int'(disp_digits), 1);

    // reset during REQ
    req_ready = 1'b0;
    press(10); press(3); press(15);
    chk("pre-reset req_valid", int'(req_valid), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset req_valid", int'(req_valid), 0);
    chk("async reset busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset disp", int'(disp_value), 0);
    chk("post-reset digits", int'(disp_digits), 0);
    press(8);
    chk("post-reset entry", int'(disp_value), 8);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
